rr_hold_arbiter: RTL and testbench

RR_HOLD_ARBITER -- requirements
Module: rr_hold_arbiter

---
 rtl/rr_hold_arbiter_if.sv | 32 +++
 rtl/rr_hold_arbiter.sv | 114 +++++++++++
 tb/tb_rr_hold_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin hold arbiter.
// master drives requests and release strobes; slave is the arbiter side.
interface rr_hold_arbiter_if #(
  parameter int unsigned NUM_PORTS = 5
);
  localparam int unsigned IdW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] req_i;
  logic [NUM_PORTS-1:0] done_i;
  logic [NUM_PORTS-1:0] gnt_o;
  logic [IdW-1:0]       gnt_id_o;
  logic                 busy_o;
  logic                 timeout_o;

  modport master (
    output req_i,
    output done_i,
    input  gnt_o,
    input  gnt_id_o,
    input  busy_o,
    input  timeout_o
  );

  modport slave (
    input  req_i,
    input  done_i,
    output gnt_o,
    output gnt_id_o,
    output busy_o,
    output timeout_o
  );
endinterface

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter that holds a grant until release, abandon or a MAX_HOLD-cycle timeout.
// All outputs are registered; at least one idle cycle separates consecutive grants.
module rr_hold_arbiter #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned MAX_HOLD  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  rr_hold_arbiter_if.slave   bus
);

  localparam int unsigned IdW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_HOLD);
  localparam logic [IdW-1:0]  LastId = IdW'(NUM_PORTS - 1);

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  state_e               state_q;
  logic [IdW-1:0]       ptr_q;
  logic [IdW-1:0]       gnt_id_q;
  logic [NUM_PORTS-1:0] gnt_q;
  logic [CntW-1:0]      hold_cnt_q;
  logic                 busy_q;
  logic                 timeout_q;

  logic                 win_vld;
  logic [IdW-1:0]       win_id;
  logic [NUM_PORTS-1:0] win_oh;
  logic [IdW-1:0]       ptr_next;
  logic                 cur_done;
  logic                 cur_req;
  logic                 rel_normal;
  logic                 rel_timeout;
  int unsigned          scan_idx;

  // First requester at or after ptr_q, wrapping around the port range.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    win_oh   = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      scan_idx = (32'(ptr_q) + k) % NUM_PORTS;
      if (!win_vld && bus.req_i[scan_idx]) begin
        win_vld          = 1'b1;
        win_id           = IdW'(scan_idx);
        win_oh           = '0;
        win_oh[scan_idx] = 1'b1;
      end
    end
  end

  assign ptr_next = ((NUM_PORTS == 1) || (win_id == LastId)) ? '0 : win_id + 1'b1;

  // gnt_q is one-hot in StGrant, so masking picks out the granted port's bits.
  assign cur_done    = |(bus.done_i & gnt_q);
  assign cur_req     = |(bus.req_i & gnt_q);
  assign rel_normal  = cur_done || !cur_req;
  assign rel_timeout = !rel_normal && (hold_cnt_q == MaxCnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      gnt_id_q   <= '0;
      gnt_q      <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_vld) begin
            state_q    <= StGrant;
            gnt_q      <= win_oh;
            gnt_id_q   <= win_id;
            busy_q     <= 1'b1;
            hold_cnt_q <= CntW'(1);
            ptr_q      <= ptr_next;
          end
        end
        StGrant: begin
          if (rel_normal || rel_timeout) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= rel_timeout;
          end else if (hold_cnt_q != MaxCnt) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.gnt_id_o  = gnt_id_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = timeout_q;

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_q));
  a_busy_match: assert property (@(posedge clk_i) disable iff (rst_i) busy_q == (gnt_q != '0));
  a_hold_range: assert property (@(posedge clk_i) disable iff (rst_i) hold_cnt_q <= MaxCnt);

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter: a cycle model checked every cycle plus literal checkpoints.
module tb_rr_hold_arbiter;

  localparam int unsigned N  = 5;
  localparam int unsigned MH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_hold_arbiter_if #(.NUM_PORTS(N)) bus ();

  rr_hold_arbiter #(
    .NUM_PORTS(N),
    .MAX_HOLD (MH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model state: who holds the grant, for how many cycles, and who is first in line next.
  bit m_busy = 1'b0;
  bit m_to   = 1'b0;
  int m_port = 0;
  int m_cnt  = 0;
  int m_ptr  = 0;

  always @(posedge clk) begin : model
    int p;
    bit hit;
    if (rst) begin
      m_busy <= 1'b0;
      m_to   <= 1'b0;
      m_port <= 0;
      m_cnt  <= 0;
      m_ptr  <= 0;
    end else if (!m_busy) begin
      m_to <= 1'b0;
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (!hit && bus.req_i[p]) begin
          hit = 1'b1;
          m_busy <= 1'b1;
          m_port <= p;
          m_cnt  <= 1;
          m_ptr  <= (p + 1) % N;
        end
      end
    end else if (bus.done_i[m_port] || !bus.req_i[m_port]) begin
      m_busy <= 1'b0;
      m_to   <= 1'b0;
    end else if (m_cnt == MH) begin
      m_busy <= 1'b0;
      m_to   <= 1'b1;
    end else begin
      m_cnt <= m_cnt + 1;
      m_to  <= 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] eg;
    int eid;
    eg  = '0;
    eid = 0;
    if (m_busy) begin
      eg[m_port] = 1'b1;
      eid        = m_port;
    end
    if (chk_en) begin
      tests++;
      if (bus.gnt_o !== eg || int'(bus.gnt_id_o) != eid || bus.busy_o !== m_busy ||
          bus.timeout_o !== m_to) begin
        fails++;
        $display("FAIL model_compare t=%0t got gnt=%b id=%0d busy=%b to=%b want gnt=%b id=%0d busy=%b to=%b",
                 $time, bus.gnt_o, bus.gnt_id_o, bus.busy_o, bus.timeout_o, eg, eid, m_busy, m_to);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [N-1:0] g, input int id, input bit b,
                     input bit to);
    tests++;
    if (bus.gnt_o !== g || int'(bus.gnt_id_o) != id || bus.busy_o !== b || bus.timeout_o !== to)
    begin
      fails++;
      $display("FAIL %s t=%0t got gnt=%b id=%0d busy=%b to=%b want gnt=%b id=%0d busy=%b to=%b",
               name, $time, bus.gnt_o, bus.gnt_id_o, bus.busy_o, bus.timeout_o, g, id, b, to);
    end
  endtask

  initial begin
    logic [N-1:0] oh;
    rst         = 1'b1;
    bus.req_i   = '0;
    bus.done_i  = '0;
    step();
    step();
    chk_en = 1'b1;
    chk("reset", 5'b00000, 0, 1'b0, 1'b0);

    // Single requester, released by done in grant cycle 3.
    rst       = 1'b0;
    bus.req_i = 5'b00001;
    step(); chk("single_c1", 5'b00001, 0, 1'b1, 1'b0);
    step(); chk("single_c2", 5'b00001, 0, 1'b1, 1'b0);
    step(); chk("single_c3", 5'b00001, 0, 1'b1, 1'b0);
    bus.done_i = 5'b00001;
    step(); chk("single_rel", 5'b00000, 0, 1'b0, 1'b0);
    bus.done_i = '0;
    bus.req_i  = '0;
    step(); chk("single_idle", 5'b00000, 0, 1'b0, 1'b0);

    // All ports requesting: each grant times out after MH cycles.
    rst = 1'b1;
    step(); chk("reset2", 5'b00000, 0, 1'b0, 1'b0);
    rst       = 1'b0;
    bus.req_i = 5'b11111;
    for (int r = 0; r < 6; r++) begin
      oh = '0;
      oh[r % N] = 1'b1;
      for (int c = 1; c <= MH; c++) begin
        step(); chk("rr_grant", oh, r % N, 1'b1, 1'b0);
      end
      step(); chk("rr_gap_timeout", 5'b00000, 0, 1'b0, 1'b1);
    end

    // Grant port 4, then pointer wraps to port 0.
    bus.req_i = 5'b10000;
    step(); chk("p4_grant", 5'b10000, 4, 1'b1, 1'b0);
    bus.done_i = 5'b10000;
    step(); chk("p4_rel", 5'b00000, 0, 1'b0, 1'b0);
    bus.done_i = '0;
    bus.req_i  = 5'b10001;
    step(); chk("wrap_p0", 5'b00001, 0, 1'b1, 1'b0);
    bus.req_i = '0;
    step(); chk("wrap_abandon", 5'b00000, 0, 1'b0, 1'b0);

    // Port 2 abandons in grant cycle 2; done on port 3 is ignored.
    bus.req_i = 5'b00100;
    step(); chk("p2_c1", 5'b00100, 2, 1'b1, 1'b0);
    bus.done_i = 5'b01000;
    step(); chk("p2_c2_foreign_done", 5'b00100, 2, 1'b1, 1'b0);
    bus.req_i = '0;
    step(); chk("p2_abandon", 5'b00000, 0, 1'b0, 1'b0);
    bus.done_i = '0;

    // Done coinciding with hold_cnt == MAX_HOLD is a normal release.
    bus.req_i = 5'b01000;
    for (int c = 1; c <= MH; c++) begin
      step(); chk("p3_hold", 5'b01000, 3, 1'b1, 1'b0);
    end
    bus.done_i = 5'b01000;
    step(); chk("done_at_max", 5'b00000, 0, 1'b0, 1'b0);
    bus.done_i = '0;
    bus.req_i  = '0;
    step(); chk("done_at_max_idle", 5'b00000, 0, 1'b0, 1'b0);

    // Reset in the middle of a grant, then arbitration restarts from port 0.
    bus.req_i = 5'b01000;
    step(); chk("p3_again", 5'b01000, 3, 1'b1, 1'b0);
    rst = 1'b1;
    step(); chk("rst_mid_grant", 5'b00000, 0, 1'b0, 1'b0);
    rst       = 1'b0;
    bus.req_i = 5'b00110;
    step(); chk("post_rst_p1", 5'b00010, 1, 1'b1, 1'b0);
    bus.req_i = '0;
    step(); chk("end_idle", 5'b00000, 0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
